btn_conditioner: RTL and testbench

Upstream input stage for the 12-hour clock/timer core. It conditions the five raw board pushbuttons (center, right, left, up, down) and gives the core clean, single-cycle events instead of raw levels. Per button it provides:
- 2-flop synchronisation
- counter-based debounce
- a one-clock press strobe
- a hold-to-repeat strobe, enabled per button, for fast up/down time setting

Its outputs drive the time-set/display mode logic directly.

---
 rtl/clk12_pkg.sv | 33 +++
 rtl/btn_channel.sv | 145 ++++++++++++++
 rtl/btn_conditioner.sv | 54 +++++
 tb/tb_btn_conditioner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/clk12_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk12_pkg                                                  |
// | Description : Shared constants and types for the 12-hour clock/timer     |
// |               core: button channel indices, default 100 MHz timing and   |
// |               the per-button auto-repeat state encoding.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package clk12_pkg;

    // Button channel indices into btn_* vectors
    localparam int BTN_DOWN   = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int N_BTN      = 5;

    // Default timing at a 100 MHz clk
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 25_000_000;  // 250 ms
    localparam logic [N_BTN-1:0] DEF_REPEAT_MASK = 5'b00011; // up, down

    // Per-channel auto-repeat state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

endpackage : clk12_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btn_channel                                                |
// | Description : One pushbutton lane: 2-flop synchroniser, counter debounce,|
// |               registered press/release edge strobes and an optional      |
// |               hold-to-repeat step generator.                             |
// | Ports       : clk, rst        clock, synchronous active-high reset       |
// |               btn_in          raw asynchronous button level              |
// |               btn_level       debounced level                            |
// |               btn_press       1-cycle strobe on debounced rising edge    |
// |               btn_step        press strobe plus auto-repeat strobes      |
// |               btn_release     1-cycle strobe on debounced falling edge   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module btn_channel
    import clk12_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_step,
    output logic btn_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    localparam logic [CW-1:0] c_deb_last = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] c_dly_last = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] c_per_last = RW'(REPEAT_PERIOD - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_release;

    rpt_state_t    r_state;
    rpt_state_t    w_state_nxt;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_step;

    // Synchroniser and debounce. The press/release strobes are produced on the
    // same edge that accepts the new level, so they coincide with the first
    // cycle btn_level shows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= btn_in;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_s2 != r_stable) begin
                if (r_cnt == c_deb_last) begin
                    r_stable  <= r_s2;
                    r_cnt     <= '0;
                    r_press   <= r_s2;
                    r_release <= ~r_s2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // Repeat FSM. A released button wins over any pending step, so the
    // release cycle never carries a step.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_step      = 1'b0;
        if (!r_stable) begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_press) begin
                        w_step      = 1'b1;
                        w_state_nxt = DELAY;
                        w_rcnt_nxt  = '0;
                    end
                end
                DELAY: begin
                    if (r_rcnt == c_dly_last) begin
                        // Unmasked channels park here with the count saturated
                        if (REPEAT_EN) begin
                            w_step      = 1'b1;
                            w_state_nxt = REPEAT;
                            w_rcnt_nxt  = '0;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_rcnt == c_per_last) begin
                        w_step     = 1'b1;
                        w_rcnt_nxt = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign btn_level   = r_stable;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_step    = w_step;

endmodule : btn_channel
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btn_conditioner                                            |
// | Description : Conditions the board pushbuttons into clean debounced      |
// |               levels and single-cycle press/step/release events. One     |
// |               independent btn_channel per button; no arbitration.        |
// | Ports       : clk, rst        clock, synchronous active-high reset       |
// |               btn_in          raw button levels (0=down .. 4=center)     |
// |               btn_level       debounced levels                           |
// |               btn_press       debounced rising-edge strobes              |
// |               btn_step        press strobes plus auto-repeat strobes     |
// |               btn_release     debounced falling-edge strobes             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module btn_conditioner #(
    parameter int               N_BTN           = clk12_pkg::N_BTN,
    parameter int               DEBOUNCE_CYCLES = clk12_pkg::DEF_DEBOUNCE_CYCLES,
    parameter int               REPEAT_DELAY    = clk12_pkg::DEF_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD   = clk12_pkg::DEF_REPEAT_PERIOD,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = clk12_pkg::DEF_REPEAT_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_step,
    output logic [N_BTN-1:0] btn_release
);

    // Counters of width $clog2(1) would collapse to zero bits
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_step    (btn_step[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_btn_conditioner                                         |
// | Description : Directed bench for btn_conditioner with short timing       |
// |               (debounce 4, repeat delay 10, repeat period 3). Expected   |
// |               strobes are queued as timed events when stimulus is driven |
// |               and compared against the DUT every cycle.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_btn_conditioner;

    localparam int NB  = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_step;
    logic [NB-1:0] btn_release;

    btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (5'b00011)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_step    (btn_step),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; rst_q = rst as seen by the last edge
    int   cyc   = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst;
    end

    typedef struct {
        int            t;
        logic [NB-1:0] prs;
        logic [NB-1:0] stp;
        logic [NB-1:0] rel;
        logic [NB-1:0] lset;
        logic [NB-1:0] lclr;
    } ev_t;

    ev_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    logic [NB-1:0] exp_lvl = '0;

    function automatic void push(int t, logic [NB-1:0] p, logic [NB-1:0] s,
                                 logic [NB-1:0] r, logic [NB-1:0] ls, logic [NB-1:0] lc);
        ev_t e;
        e.t = t; e.prs = p; e.stp = s; e.rel = r; e.lset = ls; e.lclr = lc;
        sb.push_back(e);
    endfunction

    // Buttons m first sampled high at edge k. Level/press/step appear DEB+1
    // edges later; repeats (if rep) follow RD then every RP cycles while the
    // cycle is before 'stop'. With rel, the release strobe lands at 'stop'.
    function automatic void sched(logic [NB-1:0] m, int k, int stop, bit rep, bit rel);
        push(k + DEB + 1, m, m, '0, m, '0);
        if (rep) begin
            for (int t = k + DEB + 1 + RD; t < stop; t += RP)
                push(t, '0, m, '0, '0, '0);
        end
        if (rel)
            push(stop, '0, '0, m, '0, m);
    endfunction

    task automatic check(string tag, logic [NB-1:0] obs, logic [NB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NB-1:0] ep, es, er;
        ev_t e;
        if (cyc >= 1) begin
            ep = '0; es = '0; er = '0;
            while (sb.size() > 0 && sb[0].t == cyc) begin
                e = sb.pop_front();
                ep |= e.prs;
                es |= e.stp;
                er |= e.rel;
                exp_lvl = (exp_lvl | e.lset) & ~e.lclr;
            end
            if (rst_q) exp_lvl = '0;
            check("level",   btn_level,   exp_lvl);
            check("press",   btn_press,   ep);
            check("step",    btn_step,    es);
            check("release", btn_release, er);
        end
    end

    // Drive so that the new value is sampled by edge k
    task automatic goto_edge(int k);
        while (cyc < k - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held for edges 1..3
        goto_edge(4);
        rst = 1'b0;

        // 1. Clean press of up, held 40 cycles, repeats, release
        sched(5'b00010, 10, 55, 1'b1, 1'b1);
        goto_edge(10); btn_in = 5'b00010;
        goto_edge(50); btn_in = 5'b00000;

        // 2. Bounce on left, then steady high; unmasked so no repeats
        sched(5'b00100, 80, 105, 1'b0, 1'b1);
        goto_edge(70); btn_in = 5'b00100;
        goto_edge(73); btn_in = 5'b00000;
        goto_edge(75); btn_in = 5'b00100;
        goto_edge(78); btn_in = 5'b00000;
        goto_edge(80); btn_in = 5'b00100;
        goto_edge(100); btn_in = 5'b00000;

        // 3. Three-cycle glitch on center: nothing expected
        goto_edge(120); btn_in = 5'b10000;
        goto_edge(123); btn_in = 5'b00000;

        // 4. Up and down together
        sched(5'b00011, 150, 175, 1'b1, 1'b1);
        goto_edge(150); btn_in = 5'b00011;
        goto_edge(170); btn_in = 5'b00000;

        // 5. Down held, reset for one cycle in REPEAT, re-press after reset
        sched(5'b00001, 190, 210, 1'b1, 1'b0);
        sched(5'b00001, 211, 235, 1'b1, 1'b1);
        goto_edge(190); btn_in = 5'b00001;
        goto_edge(210); rst = 1'b1;
        goto_edge(211); rst = 1'b0;
        goto_edge(230); btn_in = 5'b00000;

        // 6. Up released during DELAY (level drops at rcnt=5), then full re-press
        sched(5'b00010, 250, 261, 1'b1, 1'b1);
        sched(5'b00010, 270, 295, 1'b1, 1'b1);
        goto_edge(250); btn_in = 5'b00010;
        goto_edge(256); btn_in = 5'b00000;
        goto_edge(270); btn_in = 5'b00010;
        goto_edge(290); btn_in = 5'b00000;

        goto_edge(315);
        @(posedge clk);
        #1;
        n_assert++;
        assert (sb.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_btn_conditioner
`default_nettype wire
